// File: rtl/ahfp_div.sv
// ahfp_div: iterative binary32 divider (dataa / datab).
// Restoring mantissa divide, one quotient bit per cycle, fixed latency,
// truncating rounding, denormals flushed to zero, registered outputs.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; operands captured on the accepting edge
// SETUP  | sign, biased exponent difference, mantissas, remainder init
// DIVIDE | 25 restoring iterations, quotient shifted in MSB first
// NORM   | normalize quotient, range checks, special-operand overrides
// DONE   | done pulse; result/div_by_zero were loaded on entry
module ahfp_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_by_zero
);

    typedef enum logic [2:0] {IDLE, SETUP, DIVIDE, NORM, DONE} state_t;

    state_t state, state_nxt;

    logic [31:0]       opa, opb;
    logic              sign;
    logic signed [9:0] exp_q;
    logic [23:0]       mb;
    logic [24:0]       rem;
    logic [24:0]       quo;
    logic [4:0]        cnt;

    logic              q_bit;
    logic [23:0]       rem_sub;
    logic signed [9:0] exp_n;
    logic [22:0]       frac_n;
    logic [31:0]       res_nxt;
    logic              dbz_nxt;

    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;

    // Operand classification from the captured operands (exp 0 = zero, denormals flushed).
    always_comb begin
        a_zero = (opa[30:23] == 8'h00);
        a_inf  = (opa[30:23] == 8'hFF) && (opa[22:0] == 23'd0);
        a_nan  = (opa[30:23] == 8'hFF) && (opa[22:0] != 23'd0);
        b_zero = (opb[30:23] == 8'h00);
        b_inf  = (opb[30:23] == 8'hFF) && (opb[22:0] == 23'd0);
        b_nan  = (opb[30:23] == 8'hFF) && (opb[22:0] != 23'd0);
    end

    // One restoring step; the remainder after subtraction is always below mb, so 24 bits suffice.
    always_comb begin
        q_bit   = (rem >= {1'b0, mb});
        rem_sub = q_bit ? 24'(rem - {1'b0, mb}) : rem[23:0];
    end

    // Normalization, range clamping and special-case overrides (later checks win).
    always_comb begin
        exp_n   = quo[24] ? exp_q : exp_q - 10'sd1;
        frac_n  = quo[24] ? quo[23:1] : quo[22:0];
        res_nxt = {sign, exp_n[7:0], frac_n};
        dbz_nxt = 1'b0;
        if (exp_n >= 10'sd255) begin
            res_nxt = {sign, 8'hFF, 23'd0};
        end else if (exp_n <= 10'sd0) begin
            res_nxt = {sign, 31'd0};
        end
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res_nxt = 32'h7FC0_0000;
        end else if (a_inf || b_zero) begin
            res_nxt = {sign, 8'hFF, 23'd0};
            dbz_nxt = b_zero && !a_inf;
        end else if (a_zero || b_inf) begin
            res_nxt = {sign, 31'd0};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                busy      = 1'b1;
                state_nxt = DIVIDE;
            end
            DIVIDE: begin
                busy = 1'b1;
                if (cnt == 5'd0) begin
                    state_nxt = NORM;
                end
            end
            NORM: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers; result/div_by_zero load only on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            opa         <= 32'd0;
            opb         <= 32'd0;
            sign        <= 1'b0;
            exp_q       <= 10'sd0;
            mb          <= 24'd0;
            rem         <= 25'd0;
            quo         <= 25'd0;
            cnt         <= 5'd0;
            result      <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa <= dataa;
                        opb <= datab;
                    end
                end
                SETUP: begin
                    sign  <= opa[31] ^ opb[31];
                    exp_q <= {2'b00, opa[30:23]} - {2'b00, opb[30:23]} + 10'd127;
                    rem   <= {2'b01, opa[22:0]};
                    mb    <= {1'b1, opb[22:0]};
                    quo   <= 25'd0;
                    cnt   <= 5'd24;
                end
                DIVIDE: begin
                    quo <= {quo[23:0], q_bit};
                    rem <= {rem_sub, 1'b0};
                    cnt <= cnt - 5'd1;
                end
                NORM: begin
                    result      <= res_nxt;
                    div_by_zero <= dbz_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahfp_div.sv
// Self-checking bench for ahfp_div: directed cases, handshake/reset scenarios,
// and random operands compared against an arithmetic reference model.
module tb_ahfp_div;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    ahfp_div dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dataa       (dataa),
        .datab       (datab),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: {div_by_zero, result} from the format rules and integer division.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, e;
        logic        s, az, ai, an, bz, bi, bn;
        longint      ma, mbv, q;
        logic [22:0] frac;
        ea = {24'd0, a[30:23]};
        eb = {24'd0, b[30:23]};
        s  = a[31] ^ b[31];
        az = (ea == 0);
        ai = (ea == 255) && (a[22:0] == 23'd0);
        an = (ea == 255) && (a[22:0] != 23'd0);
        bz = (eb == 0);
        bi = (eb == 255) && (b[22:0] == 23'd0);
        bn = (eb == 255) && (b[22:0] != 23'd0);
        if (an || bn || (az && bz) || (ai && bi)) return {1'b0, 32'h7FC0_0000};
        if (ai || bz) return {bz && !ai, s, 8'hFF, 23'd0};
        if (az || bi) return {1'b0, s, 31'd0};
        ma  = {40'd0, 1'b1, a[22:0]};
        mbv = {40'd0, 1'b1, b[22:0]};
        q   = (ma << 24) / mbv;
        e   = ea - eb + 127;
        if (q >= (64'sd1 <<< 24)) begin
            frac = q[23:1];
        end else begin
            frac = q[22:0];
            e    = e - 1;
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, e[7:0], frac};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          sel;
        v   = $urandom;
        sel = $urandom_range(0, 11);
        case (sel)
            0: v[30:0] = 31'd0;
            1: v[30:0] = {8'hFF, 23'd0};
            2: v[30:23] = 8'hFF;
            3: v[30:23] = 8'h00;
            4: v[30:23] = 8'($urandom_range(1, 20));
            5: v[30:23] = 8'($urandom_range(235, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        if (sel == 2 && v[22:0] == 23'd0) v[0] = 1'b1;
        return v;
    endfunction

    // One operation; poke=1 pulses start at cycle 5 and in the done cycle (both must be ignored).
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [32:0] exp;
        int          cyc;
        int          busy_bad;
        int          extra_done;
        exp      = ref_div(a, b);
        busy_bad = 0;
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dataa = $urandom;
        datab = $urandom;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy !== 1'b1) busy_bad++;
            start = (poke && cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start = poke;
        check({tag, ".latency"}, cyc, 28);
        check({tag, ".result"}, result, exp[31:0]);
        check({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, exp[32]});
        check({tag, ".busy"}, busy_bad + (busy === 1'b1 ? 1 : 0), 0);
        @(negedge clk);
        start = 1'b0;
        check({tag, ".pulse"}, {31'd0, done}, 32'd0);
        if (poke) begin
            extra_done = 0;
            repeat (35) begin
                @(negedge clk);
                if (done === 1'b1) extra_done++;
            end
            check({tag, ".ignored_starts"}, extra_done, 0);
            check({tag, ".result_held"}, result, exp[31:0]);
        end
    endtask

    task automatic back_to_back(input logic [31:0] a, input logic [31:0] b);
        int          done_cyc[$];
        logic [32:0] exp;
        int          bad_res;
        exp     = ref_div(a, b);
        bad_res = 0;
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cyc.push_back(c);
                if (result !== exp[31:0]) bad_res++;
            end
        end
        start = 1'b0;
        check("b2b.count", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            check("b2b.first", done_cyc[0], 28);
            check("b2b.gap1", done_cyc[1] - done_cyc[0], 29);
            check("b2b.gap2", done_cyc[2] - done_cyc[1], 29);
        end
        check("b2b.results", bad_res, 0);
        repeat (40) @(negedge clk);
    endtask

    task automatic reset_abort(input logic [31:0] a, input logic [31:0] b);
        int dcount;
        dcount = 0;
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst.result", result, 32'd0);
        check("rst.dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("rst.no_done", dcount, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b1;
        start = 1'b0;
        dataa = 32'd0;
        datab = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle.result", result, 32'd0);
        check("idle.done", {31'd0, done}, 32'd0);
        check("idle.busy", {31'd0, busy}, 32'd0);
        check("idle.dbz", {31'd0, div_by_zero}, 32'd0);

        run_op("six_by_two", 32'h40C0_0000, 32'h4000_0000, 1'b0);
        check("six_by_two.value", result, 32'h4040_0000);
        run_op("one_third", 32'h3F80_0000, 32'h4040_0000, 1'b0);
        check("one_third.value", result, 32'h3EAA_AAAA);
        run_op("neg_quarter", 32'hBF80_0000, 32'h4080_0000, 1'b0);
        check("neg_quarter.value", result, 32'hBE80_0000);
        run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 1'b0);
        check("zero_zero.value", result, 32'h7FC0_0000);
        run_op("zero_num", 32'h0000_0000, 32'h3F80_0000, 1'b0);
        check("zero_num.value", result, 32'h0000_0000);
        run_op("inf_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b0);
        check("inf_inf.value", result, 32'h7FC0_0000);
        run_op("overflow", 32'h7F00_0000, 32'h0080_0000, 1'b0);
        check("overflow.value", result, 32'h7F80_0000);
        run_op("underflow", 32'h0080_0000, 32'h4000_0000, 1'b0);
        check("underflow.value", result, 32'h0000_0000);
        run_op("neg_underflow", 32'h8080_0000, 32'h4000_0000, 1'b0);
        check("neg_underflow.value", result, 32'h8000_0000);
        run_op("nan_a", 32'h7FA0_0001, 32'h3F80_0000, 1'b0);
        run_op("denorm_b", 32'hC000_0000, 32'h0000_1234, 1'b0);

        run_op("poke", 32'h40C0_0000, 32'h4000_0000, 1'b1);
        back_to_back(32'h4120_0000, 32'h4040_0000);

        run_op("one_by_zero", 32'h3F80_0000, 32'h0000_0000, 1'b0);
        check("one_by_zero.value", result, 32'h7F80_0000);
        check("one_by_zero.flag", {31'd0, div_by_zero}, 32'd1);
        reset_abort(32'h4049_0FDB, 32'h402D_F854);
        run_op("after_reset", 32'h4049_0FDB, 32'h402D_F854, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = rand_op();
            rb = rand_op();
            run_op($sformatf("rand%0d", i), ra, rb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
